// File: rtl/si5338_i2c_master.sv
// Byte-level I2C register engine for the Si5338: one register write or read per command.
// Each bus symbol is four SCL quarters; SCL/SDA levels are registered and change only on quarter boundaries.
module si5338_i2c_master #(
  parameter int         QTR_DIV  = 125,
  parameter logic [6:0] DEV_ADDR = 7'h70
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_rw,
  input  logic [7:0] cmd_reg,
  input  logic [7:0] cmd_wdata,
  output logic       rsp_valid,
  output logic       rsp_nack,
  output logic [7:0] rsp_rdata,
  output logic       scl,
  output logic       sda_oe,
  input  logic       sda_i
);

  typedef enum logic [3:0] {
    S_IDLE, S_START, S_ADDR, S_REG, S_DATA, S_RSTART, S_ADDR_R, S_RDATA, S_STOP, S_DONE
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] cnt_q;
  logic [1:0]  qtr_q;
  logic [3:0]  bit_q, bit_d;
  logic [7:0]  tx_q, tx_d;
  logic [7:0]  rx_q;
  logic        smp_q;
  logic        nack_hit_d;
  logic        rw_q;
  logic [7:0]  reg_q, wdata_q;
  logic        sda_s1_q, sda_s2_q;
  logic        scl_q, sda_oe_q, cmd_ready_q, rsp_valid_q, rsp_nack_q;
  logic [7:0]  rsp_rdata_q;

  // Bus levels {scl, sda_oe} for a given symbol and quarter; sda=1 means released.
  function automatic logic [1:0] bus_lvl(input state_t st, input logic [1:0] qtr, input logic sda);
    logic [1:0] lvl;
    case (st)
      S_START, S_RSTART: lvl = {(qtr == 2'd1) || (qtr == 2'd2), qtr[1]};
      S_STOP:            lvl = {qtr != 2'd0, ~qtr[1]};
      S_IDLE, S_DONE:    lvl = 2'b10;
      default:           lvl = {qtr[1], ~sda};
    endcase
    return lvl;
  endfunction

  // What follows the current symbol once its last quarter expires.
  // The transmit byte shifts in ones so the ACK slot and read bits leave SDA released.
  always_comb begin
    state_d    = state_q;
    tx_d       = {tx_q[6:0], 1'b1};
    bit_d      = bit_q + 4'd1;
    nack_hit_d = 1'b0;
    case (state_q)
      S_START: begin
        state_d = S_ADDR;
        tx_d    = {DEV_ADDR, 1'b0};
        bit_d   = 4'd0;
      end
      S_RSTART: begin
        state_d = S_ADDR_R;
        tx_d    = {DEV_ADDR, 1'b1};
        bit_d   = 4'd0;
      end
      S_ADDR, S_REG, S_DATA, S_ADDR_R: begin
        if (bit_q == 4'd8) begin
          bit_d = 4'd0;
          if (smp_q) begin
            state_d    = S_STOP;
            nack_hit_d = 1'b1;
          end else begin
            case (state_q)
              S_ADDR: begin
                state_d = S_REG;
                tx_d    = reg_q;
              end
              S_REG: begin
                state_d = rw_q ? S_RSTART : S_DATA;
                tx_d    = wdata_q;
              end
              S_ADDR_R: begin
                state_d = S_RDATA;
                tx_d    = 8'hFF;
              end
              default: state_d = S_STOP;
            endcase
          end
        end
      end
      S_RDATA: begin
        if (bit_q == 4'd8) begin
          state_d = S_STOP;
          bit_d   = 4'd0;
        end
      end
      S_STOP:  state_d = S_DONE;
      default: state_d = state_q;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= 16'd0;
      qtr_q       <= 2'd0;
      bit_q       <= 4'd0;
      tx_q        <= 8'd0;
      rx_q        <= 8'd0;
      smp_q       <= 1'b1;
      rw_q        <= 1'b0;
      reg_q       <= 8'd0;
      wdata_q     <= 8'd0;
      sda_s1_q    <= 1'b1;
      sda_s2_q    <= 1'b1;
      scl_q       <= 1'b1;
      sda_oe_q    <= 1'b0;
      cmd_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_nack_q  <= 1'b0;
      rsp_rdata_q <= 8'd0;
    end else begin
      sda_s1_q <= sda_i;
      sda_s2_q <= sda_s1_q;
      case (state_q)
        S_IDLE: begin
          rsp_valid_q <= 1'b0;
          if (cmd_valid && cmd_ready_q) begin
            rw_q        <= cmd_rw;
            reg_q       <= cmd_reg;
            wdata_q     <= cmd_wdata;
            cmd_ready_q <= 1'b0;
            state_q     <= S_START;
            cnt_q       <= 16'd0;
            qtr_q       <= 2'd0;
            bit_q       <= 4'd0;
            scl_q       <= 1'b0;
            sda_oe_q    <= 1'b0;
            rsp_nack_q  <= 1'b0;
            rsp_rdata_q <= 8'd0;
          end else begin
            cmd_ready_q <= 1'b1;
          end
        end
        S_DONE: begin
          rsp_valid_q <= 1'b0;
          cmd_ready_q <= 1'b1;
          state_q     <= S_IDLE;
        end
        default: begin
          if (cnt_q != 16'(QTR_DIV - 1)) begin
            cnt_q <= cnt_q + 16'd1;
          end else begin
            cnt_q <= 16'd0;
            if (qtr_q != 2'd3) begin
              qtr_q                <= qtr_q + 2'd1;
              {scl_q, sda_oe_q}    <= bus_lvl(state_q, qtr_q + 2'd1, tx_q[7]);
              // Last cycle of q2: SCL has been high for a full quarter.
              if (qtr_q == 2'd2) begin
                smp_q <= sda_s2_q;
                if (state_q == S_RDATA && bit_q != 4'd8)
                  rx_q <= {rx_q[6:0], sda_s2_q};
              end
            end else begin
              qtr_q             <= 2'd0;
              state_q           <= state_d;
              tx_q              <= tx_d;
              bit_q             <= bit_d;
              {scl_q, sda_oe_q} <= bus_lvl(state_d, 2'd0, tx_d[7]);
              if (nack_hit_d)
                rsp_nack_q <= 1'b1;
              if (state_q == S_STOP) begin
                rsp_valid_q <= 1'b1;
                if (rw_q && !rsp_nack_q)
                  rsp_rdata_q <= rx_q;
              end
            end
          end
        end
      endcase
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_nack  = rsp_nack_q;
  assign rsp_rdata = rsp_rdata_q;
  assign scl       = scl_q;
  assign sda_oe    = sda_oe_q;

endmodule

// File: tb/tb_si5338_i2c_master.sv
// Bench for si5338_i2c_master: I2C slave model with register map, scoreboard of expected
// responses (latency, NACK, read data, decoded bus trace) checked by a separate monitor.
`timescale 1ns/1ps
module tb_si5338_i2c_master;

  localparam int QTR = 4;

  logic       sys_clk = 1'b0;
  logic       sys_rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic       cmd_rw = 1'b0;
  logic [7:0] cmd_reg = 8'h00;
  logic [7:0] cmd_wdata = 8'h00;
  logic       rsp_valid, rsp_nack;
  logic [7:0] rsp_rdata;
  logic       scl, sda_oe, sda_i;
  logic       slave_oe = 1'b0;

  assign sda_i = ~(sda_oe | slave_oe);

  si5338_i2c_master #(.QTR_DIV(QTR), .DEV_ADDR(7'h70)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rw(cmd_rw),
    .cmd_reg(cmd_reg), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_nack(rsp_nack), .rsp_rdata(rsp_rdata),
    .scl(scl), .sda_oe(sda_oe), .sda_i(sda_i)
  );

  always #5 sys_clk = ~sys_clk;

  int cyc = 0;
  int acc_cnt = 0;
  int n_chk = 0;
  int n_fail = 0;
  int n_rsp = 0;

  always @(posedge sys_clk) begin
    cyc++;
    if (!sys_rst && cmd_valid && cmd_ready) acc_cnt++;
  end

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk_str(input string name, input string act, input string exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got \"%s\", want \"%s\"", name, act, exp);
    end
  endtask

  // ---------------- I2C slave model ----------------
  logic [6:0] slave_addr = 7'h70;
  bit         nack_data = 1'b0;
  logic [7:0] mem [256];
  logic [7:0] rxbyte = 8'h00, txbyte = 8'h00, reg_ptr = 8'h00;
  int         bitpos = 0, byte_idx = 0;
  bit         transmitting = 1'b0, addressed = 1'b0, in_frame = 1'b0;
  logic       prev_scl = 1'b1, prev_sda = 1'b1;
  string      slave_log = "";

  function automatic void log_tok(input string tok);
    slave_log = (slave_log.len() == 0) ? tok : {slave_log, " ", tok};
  endfunction

  always @(negedge sys_clk) begin
    logic s;
    s = sda_i;
    if (scl && prev_scl && prev_sda && !s) begin
      log_tok("S");
      bitpos = 0; byte_idx = 0; transmitting = 1'b0; in_frame = 1'b1; slave_oe = 1'b0;
    end else if (scl && prev_scl && !prev_sda && s) begin
      log_tok("P");
      in_frame = 1'b0; transmitting = 1'b0; slave_oe = 1'b0;
    end else if (in_frame && scl && !prev_scl) begin
      if (bitpos < 8) begin
        if (!transmitting) rxbyte = {rxbyte[6:0], s};
        bitpos++;
      end else begin
        bitpos = 0;
        if (transmitting) begin
          log_tok($sformatf("%02h%s", txbyte, s ? "-" : "+"));
          transmitting = 1'b0;
        end else begin
          log_tok($sformatf("%02h%s", rxbyte, s ? "-" : "+"));
          if (byte_idx == 0) begin
            addressed = (rxbyte[7:1] == slave_addr);
            if (addressed && rxbyte[0]) begin
              transmitting = 1'b1;
              txbyte = mem[reg_ptr];
            end
          end else if (byte_idx == 1 && addressed && !s) begin
            reg_ptr = rxbyte;
          end else if (byte_idx == 2 && addressed && !s) begin
            mem[reg_ptr] = rxbyte;
          end
        end
        byte_idx++;
      end
    end else if (in_frame && !scl && prev_scl) begin
      if (transmitting && bitpos < 8)
        slave_oe = ~txbyte[7 - bitpos];
      else if (!transmitting && bitpos == 8)
        slave_oe = (byte_idx == 0) ? (rxbyte[7:1] == slave_addr)
                                   : (addressed && !(nack_data && byte_idx == 2));
      else
        slave_oe = 1'b0;
    end
    prev_scl = scl;
    prev_sda = sda_i;
  end

  // ---------------- scoreboard ----------------
  typedef struct {
    logic       nack;
    logic [7:0] rdata;
    int         lat;
    string      bus;
    int         t_acc;
  } exp_t;
  exp_t sb[$];

  always @(negedge sys_clk) begin
    if (!sys_rst && rsp_valid) begin
      if (sb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_rsp: got rsp_valid at cycle %0d, want none", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        n_rsp++;
        $display("rsp %0d: lat=%0d nack=%0d rdata=%02h bus=\"%s\"",
                 n_rsp, cyc - e.t_acc, rsp_nack, rsp_rdata, slave_log);
        chk("rsp_latency", cyc - e.t_acc, e.lat);
        chk("rsp_nack", int'(rsp_nack), int'(e.nack));
        chk("rsp_rdata", int'(rsp_rdata), int'(e.rdata));
        chk_str("bus_trace", slave_log, e.bus);
      end
      slave_log = "";
    end
  end

  // ---------------- stimulus ----------------
  task automatic send(input bit rw, input logic [7:0] r, input logic [7:0] d,
                      input bit nk, input logic [7:0] rd, input int lat,
                      input string bus, input bit push);
    int n;
    n = 0;
    @(negedge sys_clk);
    cmd_valid = 1'b1; cmd_rw = rw; cmd_reg = r; cmd_wdata = d;
    while (!cmd_ready && n < 2000) begin
      @(negedge sys_clk);
      n++;
    end
    if (!cmd_ready) begin
      chk("accept_timeout", 0, 1);
      cmd_valid = 1'b0;
      return;
    end
    chk("idle_scl", int'(scl), 1);
    chk("idle_sda_oe", int'(sda_oe), 0);
    if (push) sb.push_back('{nk, rd, lat, bus, cyc});
    @(negedge sys_clk);
    cmd_valid = 1'b0; cmd_rw = ~rw; cmd_reg = 8'h00; cmd_wdata = 8'hFF;
  endtask

  task automatic wait_rsp();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 3000) begin
      @(posedge sys_clk);
      n++;
    end
    if (sb.size() != 0) begin
      chk("rsp_timeout", int'(sb.size()), 0);
      sb.delete();
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'hDA] = 8'h01;
  end

  initial begin
    int acc0, n;
    repeat (3) @(negedge sys_clk);
    chk("rst_scl", int'(scl), 1);
    chk("rst_sda_oe", int'(sda_oe), 0);
    chk("rst_cmd_ready", int'(cmd_ready), 0);
    chk("rst_rsp_valid", int'(rsp_valid), 0);
    chk("rst_rsp_nack", int'(rsp_nack), 0);
    chk("rst_rsp_rdata", int'(rsp_rdata), 0);
    sys_rst = 1'b0;
    @(negedge sys_clk);
    chk("ready_after_rst", int'(cmd_ready), 1);

    send(0, 8'hE6, 8'h10, 0, 8'h00, 465, "S e0+ e6+ 10+ P", 1); wait_rsp();
    send(1, 8'hDA, 8'h00, 0, 8'h01, 625, "S e0+ da+ S e1+ 01- P", 1); wait_rsp();
    send(1, 8'hE6, 8'h00, 0, 8'h10, 625, "S e0+ e6+ S e1+ 10- P", 1); wait_rsp();

    slave_addr = 7'h71;
    send(0, 8'h05, 8'hAA, 1, 8'h00, 177, "S e0- P", 1); wait_rsp();
    slave_addr = 7'h70;

    nack_data = 1'b1;
    send(0, 8'h07, 8'h55, 1, 8'h00, 465, "S e0+ 07+ 55- P", 1); wait_rsp();
    nack_data = 1'b0;

    // cmd_valid held through a whole transaction, fields changed after acceptance
    acc0 = acc_cnt;
    @(negedge sys_clk);
    cmd_valid = 1'b1; cmd_rw = 1'b0; cmd_reg = 8'h21; cmd_wdata = 8'h5A;
    n = 0;
    while (!cmd_ready && n < 2000) begin @(negedge sys_clk); n++; end
    sb.push_back('{1'b0, 8'h00, 465, "S e0+ 21+ 5a+ P", cyc});
    @(negedge sys_clk);
    cmd_wdata = 8'hA5; cmd_reg = 8'h99;
    n = 0;
    while (!rsp_valid && n < 2000) begin @(negedge sys_clk); n++; end
    cmd_valid = 1'b0;
    chk("busy_accepts", acc_cnt - acc0, 1);
    wait_rsp();

    send(0, 8'h30, 8'h11, 0, 8'h00, 465, "S e0+ 30+ 11+ P", 1); wait_rsp();
    send(0, 8'h31, 8'h22, 0, 8'h00, 465, "S e0+ 31+ 22+ P", 1); wait_rsp();
    send(1, 8'h31, 8'h00, 0, 8'h22, 625, "S e0+ 31+ S e1+ 22- P", 1); wait_rsp();

    // reset while the register byte is on the bus
    send(0, 8'h33, 8'h44, 0, 8'h00, 0, "", 0);
    repeat (170) @(negedge sys_clk);
    sys_rst = 1'b1;
    @(negedge sys_clk);
    chk("midrst_scl", int'(scl), 1);
    chk("midrst_sda_oe", int'(sda_oe), 0);
    chk("midrst_rsp_valid", int'(rsp_valid), 0);
    chk("midrst_cmd_ready", int'(cmd_ready), 0);
    repeat (2) @(negedge sys_clk);
    sys_rst = 1'b0;
    @(posedge sys_clk);
    slave_log = ""; in_frame = 1'b0; slave_oe = 1'b0;
    @(negedge sys_clk);
    chk("midrst_ready_after", int'(cmd_ready), 1);
    repeat (700) @(negedge sys_clk);

    send(0, 8'h40, 8'h77, 0, 8'h00, 465, "S e0+ 40+ 77+ P", 1); wait_rsp();
    send(1, 8'h40, 8'h00, 0, 8'h77, 625, "S e0+ 40+ S e1+ 77- P", 1); wait_rsp();

    repeat (10) @(negedge sys_clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #800000;
    $display("FAIL watchdog: got no end of test by cycle %0d, want completion", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/si5338_i2c_master.md
# si5338_i2c_master

Byte-level I2C register-access engine for the Si5338 clock generator. It runs on the board system clock and executes one register write or one register read per command over the SCL/SDA pins. It sits directly below the Si5338 init sequencer, which issues (register, data) commands and waits for each response before sending the next. The top level performs the open-drain SDA tristate from `sda_oe`/`sda_i`.

## Interface
Parameters:
- `QTR_DIV`, default 125: `sys_clk` cycles per SCL quarter-period. 125 gives 100 kHz at 50 MHz. Legal range is 4..65535.
- `DEV_ADDR`, default 7'h70: 7-bit Si5338 slave address.

Ports:
- `sys_clk`, in, 1: single clock for all logic.
- `sys_rst`, in, 1: synchronous, active-high reset.
- `cmd_valid`, in, 1: command request.
- `cmd_ready`, out, 1: engine idle; a command is accepted on `cmd_valid & cmd_ready`.
- `cmd_rw`, in, 1: 0 = write, 1 = read.
- `cmd_reg`, in, 8: Si5338 register address.
- `cmd_wdata`, in, 8: write data. Ignored for reads.
- `rsp_valid`, out, 1: one-cycle pulse at transaction end.
- `rsp_nack`, out, 1: slave NACKed. Valid with `rsp_valid`.
- `rsp_rdata`, out, 8: read byte. Valid with `rsp_valid` on reads; holds 0 otherwise.
- `scl`, out, 1: SCL level, driven push-pull. 1 = high.
- `sda_oe`, out, 1: 1 = pull SDA low; 0 = release.
- `sda_i`, in, 1: SDA pin level. Asynchronous; the block synchronizes it internally with 2 flops.

## Operation
Command fields are captured on acceptance; later changes on the inputs have no effect.

**Symbol sequencing.** A quarter counter counts 0..QTR_DIV-1. Each symbol is 4 quarters, q0..q3, so it lasts 4·QTR_DIV cycles. Notation below is SCL/SDA, where SDA 1 means released.
- START: q0 = 0/1, q1 = 1/1, q2 = 1/0, q3 = 0/0. The same sequence serves first and repeated START.
- BIT: SDA set in q0 and held through q3. SCL is q0 = 0, q1 = 0, q2 = 1, q3 = 1. Input is sampled from the synchronized `sda_i` on the last cycle of q2.
- STOP: q0 = 0/0, q1 = 1/0, q2 = 1/1, q3 = 1/1.

**Frames.** Bytes are sent MSB first; each is followed by one ACK bit with SDA released. ACK means sampled 0.
- Write (29 symbols): START, {DEV_ADDR,0}+ACK, reg+ACK, wdata+ACK, STOP.
- Read (39 symbols): START, {DEV_ADDR,0}+ACK, reg+ACK, START, {DEV_ADDR,1}+ACK, 8 data bits with SDA released, master NACK (SDA released), STOP.

**NACK handling.** A sampled 1 in any slave-ACK slot ends that ACK symbol, then goes straight to STOP and sets `rsp_nack=1`.

**State machine.** IDLE → START → ADDR → REG → (write: DATA | read: RSTART → ADDR_R → RDATA) → STOP → DONE → IDLE.
- DONE lasts one cycle and pulses `rsp_valid`.
- IDLE drives `cmd_ready=1`, `scl=1`, `sda_oe=0`.

**Unsupported.** Clock stretching and multi-master arbitration are not supported. SCL is never read back.

## Timing
Reset values, forced while `sys_rst=1`:
- `scl=1`, `sda_oe=0`, `cmd_ready=0`, `rsp_valid=0`, `rsp_nack=0`, `rsp_rdata=0`.
- State = IDLE. `cmd_ready` rises on the first cycle after `sys_rst` falls.

Acceptance and response:
- On acceptance at cycle T, `cmd_ready` is 0 from T+1.
- START q0 starts at T+1.
- `rsp_valid` is high at cycle T+1+4·QTR_DIV·N, where N = 29 (write), 39 (read), or (symbols through the failing ACK) + 1 (NACK).
- `cmd_ready` returns to 1 on the cycle after `rsp_valid`.
- `rsp_nack` and `rsp_rdata` hold until the next acceptance.
- `cmd_valid` while `cmd_ready=0` is ignored; the command is not queued.

Output and sampling rules:
- `scl` and `sda_oe` are registered outputs and change only at quarter boundaries.
- SDA changes only while SCL is low, except inside START and STOP.
- Input sampling latency is 2 synchronizer cycles plus the sample point. `QTR_DIV ≥ 4` guarantees the sampled value is stable.

Reset mid-transaction: on the next cycle `scl=1` and `sda_oe=0`, the FSM returns to IDLE, no `rsp_valid` is produced, and no STOP is generated.

## Test plan
All scenarios use QTR_DIV = 4 and a bench I2C slave model at address 0x70.
- **Write with ACK.** Write reg 0xE6, data 0x10. Required on the bus: START, 0xE0, A, 0xE6, A, 0x10, A, STOP. `rsp_valid` arrives at T+465 with `rsp_nack=0`.
- **Read.** Read reg 0xDA; the model returns 0x01. Required on the bus: 0xE0, 0xDA, repeated START, 0xE1, data, master NACK, STOP. `rsp_valid` arrives at T+625 with `rsp_rdata=0x01`.
- **Address NACK.** Model set to address 0x71. Expect STOP after the first ACK slot, `rsp_nack=1`, and `rsp_valid` at T+177.
- **Data NACK.** Model NACKs the data byte of a write. Expect STOP right after the third ACK, `rsp_nack=1`, and `rsp_valid` at T+465.
- **Busy and back-to-back.** Hold `cmd_valid` during a transaction: there is no second acceptance before `rsp_valid`. Then issue two back-to-back writes: both complete and the bus is idle between them.
- **Reset mid-transaction.** Assert `sys_rst` during the REG byte. Next cycle `scl=1` and `sda_oe=0`; there is no `rsp_valid`; `cmd_ready=1` one cycle after release; a following write completes normally.
